// File: rtl/regfile_if.sv
// Register-file bus: two read ports, the write-back port and the load scoreboard.
// The master drives addresses, write data and the scoreboard set; the slave returns read data and busy flags.
interface regfile_if;
    logic [4:0]  ra_addr;
    logic [31:0] ra_data;
    logic [4:0]  rb_addr;
    logic [31:0] rb_data;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic        rf_we;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] busy_vec;

    modport master (
        output ra_addr, rb_addr, rf_w_addr, rf_w_data, rf_we, sb_set, sb_addr,
        input  ra_data, rb_data, busy_a, busy_b, busy_vec
    );

    modport slave (
        input  ra_addr, rb_addr, rf_w_addr, rf_w_data, rf_we, sb_set, sb_addr,
        output ra_data, rb_data, busy_a, busy_b, busy_vec
    );
endinterface

// File: rtl/regfile.sv
// 31 x 32-bit register file (R31 reads as zero) with a per-register pending-load scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto a matching read port.
module regfile (
    input  logic      clk,
    input  logic      rst_n,
    regfile_if.slave  rf
);
    localparam int unsigned NREGS = 31;

    logic [31:0] regs_q [0:NREGS-1];
    logic [31:0] regs_d [0:NREGS-1];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic we_ok;
    logic sb_ok;

    assign we_ok = rf.rf_we  && (rf.rf_w_addr != 5'd31);
    assign sb_ok = rf.sb_set && (rf.sb_addr   != 5'd31);

    // Clear is applied before set so a load reissued in the write-back cycle stays pending.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we_ok) begin
            regs_d[rf.rf_w_addr] = rf.rf_w_data;
            busy_d[rf.rf_w_addr] = 1'b0;
        end
        if (sb_ok) begin
            busy_d[rf.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'h0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        val = 32'h0;
        if (addr != 5'd31) begin
`ifdef RF_BYPASS_EN
            if (we_ok && (rf.rf_w_addr == addr)) begin
                val = rf.rf_w_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    assign rf.ra_data  = read_port(rf.ra_addr);
    assign rf.rb_data  = read_port(rf.rb_addr);
    assign rf.busy_vec = {1'b0, busy_q};
    assign rf.busy_a   = rf.busy_vec[rf.ra_addr];
    assign rf.busy_b   = rf.busy_vec[rf.rb_addr];
endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: directed scenarios followed by a random write/read/scoreboard run
// compared against an array-based reference model.
module tb_regfile;
    logic clk = 1'b0;
    logic rst_n;

    regfile_if rf_bus ();

    regfile u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [0:30];
    logic [31:0] m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic sb, input logic [4:0] sbaddr,
                         input logic [4:0] ra, input logic [4:0] rb);
        rf_bus.rf_we     = we;
        rf_bus.rf_w_addr = waddr;
        rf_bus.rf_w_data = wdata;
        rf_bus.sb_set    = sb;
        rf_bus.sb_addr   = sbaddr;
        rf_bus.ra_addr   = ra;
        rf_bus.rb_addr   = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 31; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
    endtask

    // Expected read value: R31 is always zero; otherwise the stored value, or the
    // incoming write data when forwarding is built in.
    function automatic logic [31:0] exp_read(input logic [4:0] addr, input logic we,
                                             input logic [4:0] waddr, input logic [31:0] wdata);
        if (addr == 5'd31) return 32'h0;
`ifdef RF_BYPASS_EN
        if (we && waddr == addr) return wdata;
`endif
        return m_regs[addr];
    endfunction

    task automatic model_edge(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic sb, input logic [4:0] sbaddr);
        if (we && waddr != 5'd31) begin
            m_regs[waddr] = wdata;
            m_busy[waddr] = 1'b0;
        end
        if (sb && sbaddr != 5'd31) m_busy[sbaddr] = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_a;
        logic        we;
        logic        sb;
        logic [4:0]  waddr;
        logic [4:0]  sbaddr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] wdata;

        // Reset and read every address on both ports
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        #22;
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            rf_bus.ra_addr = 5'(i);
            rf_bus.rb_addr = 5'(31 - i);
            #1;
            chk($sformatf("rst_ra[%0d]", i), rf_bus.ra_data, 32'h0);
            chk($sformatf("rst_rb[%0d]", 31 - i), rf_bus.rb_data, 32'h0);
        end
        chk("rst_busy_vec", rf_bus.busy_vec, 32'h0);
        $display("txn reset: all addresses read back");

        // Write R5, read on both ports next cycle; write R31 has no effect
        tick();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        chk("r5_port_a", rf_bus.ra_data, 32'hDEADBEEF);
        chk("r5_port_b", rf_bus.rb_data, 32'hDEADBEEF);
        $display("txn write R5=deadbeef");
        drive(1'b1, 5'd31, 32'h1234, 1'b0, 5'd0, 5'd31, 5'd5);
        #1;
        chk("r31_same_cycle", rf_bus.ra_data, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd5);
        #1;
        chk("r31_after_write", rf_bus.ra_data, 32'h0);
        chk("r5_unaffected", rf_bus.rb_data, 32'hDEADBEEF);
        $display("txn write R31=1234 ignored");

        // Same-cycle read of the register being written
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
`ifdef RF_BYPASS_EN
        chk("r7_same_cycle", rf_bus.ra_data, 32'hA5A5A5A5);
`else
        chk("r7_same_cycle", rf_bus.ra_data, 32'h0);
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        chk("r7_next_cycle", rf_bus.rb_data, 32'hA5A5A5A5);
        $display("txn write R7=a5a5a5a5");

        // Scoreboard set, clear, set-wins, different-address, address 31
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
        #1;
        chk("sb3_no_bypass", {31'b0, rf_bus.busy_a}, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        chk("sb3_busy_vec", rf_bus.busy_vec, 32'h8);
        chk("sb3_busy_a", {31'b0, rf_bus.busy_a}, 32'h1);
        chk("sb3_busy_b", {31'b0, rf_bus.busy_b}, 32'h0);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        chk("wb3_clears", rf_bus.busy_vec, 32'h0);
        drive(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        chk("set_wins", rf_bus.busy_vec, 32'h8);
        chk("set_wins_data", rf_bus.ra_data, 32'h44);
        drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 5'd3, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd4);
        #1;
        chk("diff_addr_and_sb31", rf_bus.busy_vec, 32'h10);
        chk("busy_b_r4", {31'b0, rf_bus.busy_b}, 32'h1);
        chk("busy_a_r31", {31'b0, rf_bus.busy_a}, 32'h0);
        $display("txn scoreboard sequence");

        // Fill R0..R30 with their index, then reset asynchronously between edges
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 5'(i), 32'(i), 1'b1, 5'(i), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd30, 5'd12);
        #1;
        chk("fill_r30", rf_bus.ra_data, 32'd30);
        chk("fill_r12", rf_bus.rb_data, 32'd12);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r30", rf_bus.ra_data, 32'h0);
        chk("async_rst_r12", rf_bus.rb_data, 32'h0);
        chk("async_rst_busy", rf_bus.busy_vec, 32'h0);
        drive(1'b1, 5'd9, 32'hFFFF0000, 1'b1, 5'd9, 5'd9, 5'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_ignores_write", rf_bus.ra_data, 32'h0);
        chk("rst_ignores_sb", rf_bus.busy_vec, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rf_bus.rb_addr = 5'(i);
            #0.1;
            chk($sformatf("post_rst_rb[%0d]", i), rf_bus.rb_data, 32'h0);
        end
        model_clear();
        tick();
        model_edge(1'b1, 5'd9, 32'hFFFF0000, 1'b1, 5'd9);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd1);
        #1;
        chk("first_edge_write", rf_bus.ra_data, 32'hFFFF0000);
        chk("first_edge_sb", rf_bus.busy_vec, 32'h200);
        $display("txn async reset sequence");

        // Random traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            we     = 1'($urandom_range(0, 1));
            sb     = ($urandom_range(0, 3) == 0);
            waddr  = 5'($urandom);
            sbaddr = 5'($urandom);
            ra     = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            rb     = 5'($urandom);
            wdata  = $urandom;
            drive(we, waddr, wdata, sb, sbaddr, ra, rb);
            if (!we) begin
                rf_bus.rf_w_data = 'x;
                rf_bus.rf_w_addr = 'x;
            end
            #1;
            exp_a = exp_read(ra, we, waddr, wdata);
            chk("rnd_ra_data", rf_bus.ra_data, exp_a);
            chk("rnd_rb_data", rf_bus.rb_data, exp_read(rb, we, waddr, wdata));
            chk("rnd_ra_known", {31'b0, $isunknown(rf_bus.ra_data)}, 32'h0);
            chk("rnd_rb_known", {31'b0, $isunknown(rf_bus.rb_data)}, 32'h0);
            chk("rnd_busy_vec", rf_bus.busy_vec, m_busy);
            chk("rnd_busy_a", {31'b0, rf_bus.busy_a}, {31'b0, m_busy[ra]});
            chk("rnd_busy_b", {31'b0, rf_bus.busy_b}, {31'b0, m_busy[rb]});
            $display("txn %0d we=%0d w%0d=%h sb=%0d s%0d ra%0d=%h rb%0d", t, we, waddr, wdata,
                     sb, sbaddr, ra, rf_bus.ra_data, rb);
            tick();
            model_edge(we, waddr, wdata, sb, sbaddr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
